// File: rtl/kbd_pkg.sv
// Shared types and code-field positions for the keyboard auto-type injector.
package kbd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FREE,
    SHIFT_SETUP,
    PRESS,
    RELEASE_GAP
  } state_t;

  localparam int CODE_SHIFT_BIT = 7;
  localparam int CODE_ROW_MSB   = 6;
  localparam int CODE_ROW_LSB   = 4;
  localparam int CODE_PAUSE_BIT = 3;
  localparam int CODE_COL_MSB   = 2;

  localparam int SHIFT_ROW = 1;
  localparam int SHIFT_COL = 3;

endpackage

// File: rtl/kbd_delay_timer.sv
// Loadable down-counter; holds at zero until reloaded.
module kbd_delay_timer #(
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/kbd_autotype.sv
// Injects matrix key codes into the LM80C keyboard matrix as timed
// shift-setup / press / release phases, AND-merged with the PS/2 matrix.
module kbd_autotype
  import kbd_pkg::*;
#(
  parameter int HOLD_CYCLES        = 60000,
  parameter int GAP_CYCLES         = 60000,
  parameter int SHIFT_SETUP_CYCLES = 10000,
  parameter int CNT_W              = 17
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0][7:0] KM_ps2,
  output logic [7:0][7:0] KM,
  input  logic [7:0]      code,
  input  logic            code_valid,
  output logic            code_ready,
  input  logic            abort,
  output logic            busy
);

  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SHIFT_SETUP_CYCLES - 1);

  state_t          state_reg, state_next;
  logic            shift_reg;
  logic [2:0]      row_reg, col_reg;
  logic            transfer;
  logic            timer_load, timer_zero;
  logic [CNT_W-1:0] timer_value;
  logic [7:0][7:0] mask;
  logic [7:0][7:0] km_next;

  assign transfer = code_valid && code_ready;

  // State register and code latch
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      shift_reg <= 1'b0;
      row_reg   <= '0;
      col_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (transfer) begin
        shift_reg <= code[CODE_SHIFT_BIT];
        row_reg   <= code[CODE_ROW_MSB:CODE_ROW_LSB];
        col_reg   <= code[CODE_COL_MSB:0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:        if (transfer) state_next = code[CODE_PAUSE_BIT] ? RELEASE_GAP : WAIT_FREE;
      WAIT_FREE:   if (&KM_ps2) state_next = shift_reg ? SHIFT_SETUP : PRESS;
      SHIFT_SETUP: if (timer_zero) state_next = PRESS;
      PRESS:       if (timer_zero) state_next = RELEASE_GAP;
      RELEASE_GAP: if (timer_zero) state_next = IDLE;
      default:     state_next = IDLE;
    endcase
    if (abort && state_reg != IDLE) state_next = IDLE;
  end

  // Every state change reloads the timer with the length of the state being entered
  always_comb begin
    timer_load  = (state_next != state_reg);
    timer_value = '0;
    case (state_next)
      SHIFT_SETUP: timer_value = SETUP_LD;
      PRESS:       timer_value = HOLD_LD;
      RELEASE_GAP: timer_value = GAP_LD;
      default:     timer_value = '0;
    endcase
  end

  kbd_delay_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  always_comb begin
    mask       = '0;
    busy       = (state_reg != IDLE);
    code_ready = (state_reg == IDLE) && !reset;
    case (state_reg)
      SHIFT_SETUP: mask[SHIFT_ROW][SHIFT_COL] = 1'b1;
      PRESS: begin
        mask[row_reg][col_reg] = 1'b1;
        if (shift_reg) mask[SHIFT_ROW][SHIFT_COL] = 1'b1;
      end
      default: mask = '0;
    endcase
    // abort drops the key in the same cycle so KM is clean one cycle later
    if (abort) mask = '0;
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_row
    assign km_next[gi] = KM_ps2[gi] & ~mask[gi];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      KM <= '1;
    end else begin
      KM <= km_next;
    end
  end

endmodule

// File: tb/tb_kbd_autotype.sv
// Directed bench for kbd_autotype with short timings (HOLD=4, GAP=3, SETUP=2).
module tb_kbd_autotype;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0][7:0] KM_ps2;
  logic [7:0][7:0] KM;
  logic [7:0]      code;
  logic            code_valid;
  logic            code_ready;
  logic            abort;
  logic            busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  kbd_autotype #(
    .HOLD_CYCLES        (4),
    .GAP_CYCLES         (3),
    .SHIFT_SETUP_CYCLES (2),
    .CNT_W              (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .KM_ps2     (KM_ps2),
    .KM         (KM),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .abort      (abort),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] key(input int r, input int c);
    logic [63:0] v;
    v = '1;
    v[r*8 + c] = 1'b0;
    return v;
  endfunction

  // Offer a code for one cycle; returns in cycle t+1 after the transfer edge
  task automatic send(input logic [7:0] c);
    code       = c;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_drain"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [63:0] exp;
    reset = 1'b1; KM_ps2 = '1; code = '0; code_valid = 1'b0; abort = 1'b0;
    tick(); tick();
    check("rst_km", KM, '1);
    check("rst_ready", 64'(code_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", 64'(code_ready), 64'd1);
    $display("transaction reset done");

    // Plain key 5,2
    send(8'h52);
    check("plain_t1_busy", 64'(busy), 64'd1);
    for (int i = 2; i <= 9; i++) begin
      tick();
      exp = (i >= 3 && i <= 6) ? key(5, 2) : '1;
      check($sformatf("plain_km_%0d", i), KM, exp);
      check($sformatf("plain_busy_%0d", i), 64'(busy), (i <= 8) ? 64'd1 : 64'd0);
    end
    check("plain_ready", 64'(code_ready), 64'd1);
    $display("transaction plain 52 done");

    // Shifted key 2,6
    send(8'hA6);
    for (int i = 2; i <= 11; i++) begin
      tick();
      exp = '1;
      if (i >= 3 && i <= 8) exp[1*8 + 3] = 1'b0;
      if (i >= 5 && i <= 8) exp[2*8 + 6] = 1'b0;
      check($sformatf("shift_km_%0d", i), KM, exp);
    end
    check("shift_busy", 64'(busy), 64'd0);
    $display("transaction shifted A6 done");

    // Physical key 3,1 held for 10 cycles delays injection of 0,0
    KM_ps2[3][1] = 1'b0;
    send(8'h00);
    for (int i = 1; i <= 18; i++) begin
      if (i > 1) tick();
      if (i == 10) KM_ps2[3][1] = 1'b1;
      exp = '1;
      if (i <= 10) exp[3*8 + 1] = 1'b0;
      if (i >= 12 && i <= 15) exp[0] = 1'b0;
      check($sformatf("wait_km_%0d", i), KM, exp);
      check($sformatf("wait_busy_%0d", i), 64'(busy), (i <= 17) ? 64'd1 : 64'd0);
    end
    $display("transaction busy-wait 00 done");

    // Pause code
    send(8'h08);
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) tick();
      check($sformatf("pause_km_%0d", i), KM, '1);
      check($sformatf("pause_busy_%0d", i), 64'(busy), (i <= 3) ? 64'd1 : 64'd0);
    end
    $display("transaction pause 08 done");

    // Abort in the second PRESS cycle
    send(8'h00);
    tick(); tick();
    check("abort_pre_km", KM, key(0, 0));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_km", KM, '1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(code_ready), 64'd1);
    $display("transaction abort 00 done");

    // abort in IDLE does not block a transfer
    abort = 1'b1;
    send(8'h08);
    abort = 1'b0;
    check("idle_abort_busy", 64'(busy), 64'd1);
    drain("idle_abort");
    $display("transaction idle-abort 08 done");

    // Reset in the middle of PRESS
    send(8'h00);
    tick(); tick();
    check("rstmid_pre_km", KM, key(0, 0));
    reset = 1'b1;
    tick();
    check("rstmid_km", KM, '1);
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_ready", 64'(code_ready), 64'd0);
    reset = 1'b0;
    send(8'h52);
    check("rstmid_accept", 64'(busy), 64'd1);
    tick(); tick();
    check("rstmid_new_km", KM, key(5, 2));
    drain("rstmid");
    $display("transaction reset-mid 52 done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
